// File: rtl/linear_sensor_model_pkg.sv
// linear_sensor_model_pkg
//   Shared types and default constants for the linear sensor model.
//   sensor_state_t : sensor-side sequencing states
//   N_PIX_DEF      : default pixels per line
//   LEAD_DEF       : default SENSOR_CLK rises from ST falling to pixel 0
//   MIN_INTEG      : shortest legal integration (used by the optional checker)
package linear_sensor_model_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INTEG,
        LEAD_WAIT,
        READOUT,
        EOC_HI
    } sensor_state_t;

    localparam int N_PIX_DEF = 1024;
    localparam int LEAD_DEF  = 48;
    localparam int MIN_INTEG = 6;

endpackage

// File: rtl/linear_sensor_model_sck_rise_det.sv
// sck_rise_det
//   Detects rising edges of SENSOR_CLK, which is sampled as plain data in
//   the FPGA_CLK domain.
//   clk   : FPGA_CLK
//   rst_n : asynchronous active-low reset
//   sck   : SENSOR_CLK sample input
//   rise  : combinational, high in the cycle where sck is 1 and was 0
//   The history register resets to 1 so a SENSOR_CLK that is already high
//   when reset releases is not mistaken for a rising edge.
module sck_rise_det
    import linear_sensor_model_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    output logic rise
);

    logic sck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 1'b1;
        end else begin
            sck_q <= sck;
        end
    end

    assign rise = sck & ~sck_q;

endmodule

// File: rtl/linear_sensor_model.sv
// linear_sensor_model
//   Sensor-side model of the SENSOR_CLK/ST/EOC drive interface. Consumes the
//   drive outputs and produces the pixel stream, EOS and EOC, all in the
//   FPGA_CLK domain. Every state change happens on the FPGA_CLK edge where a
//   SENSOR_CLK rise is detected.
//   FPGA_CLK   : system clock
//   FPGA_RST   : asynchronous active-low reset
//   SENSOR_CLK : divided sensor clock, sampled as data
//   ST         : start/integration request, sampled on SENSOR_CLK rise
//   VIDEO      : current pixel value, held between strobes
//   PIX_VALID  : one-cycle strobe per pixel
//   EOS        : one-cycle strobe coincident with the last PIX_VALID
//   EOC        : high for one SENSOR_CLK period after readout
//   INTEG_LEN  : integration length of the last frame in SENSOR_CLK rises
//   FRAME_CNT  : completed frames, wrapping
//   ST_ERR     : sticky protocol error flag, present only when
//                LINEAR_SENSOR_MODEL_CHECK_EN is defined
module linear_sensor_model
    import linear_sensor_model_pkg::*;
#(
    parameter int N_PIX   = N_PIX_DEF,
    parameter int LEAD    = LEAD_DEF,
    parameter int DATA_W  = 12,
    parameter int INTEG_W = 21,
    parameter int FRAME_W = 16
) (
    input  logic               FPGA_CLK,
    input  logic               FPGA_RST,
    input  logic               SENSOR_CLK,
    input  logic               ST,
    output logic [DATA_W-1:0]  VIDEO,
    output logic               PIX_VALID,
    output logic               EOS,
    output logic               EOC,
    output logic [INTEG_W-1:0] INTEG_LEN,
    output logic [FRAME_W-1:0] FRAME_CNT
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
    ,
    output logic               ST_ERR
`endif
);

    localparam int PIX_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int LEAD_W = $clog2(LEAD + 1);

    function automatic logic [DATA_W-1:0] pixel_value(input logic [PIX_W-1:0] idx,
                                                      input logic [FRAME_W-1:0] frame);
        return DATA_W'(32'(idx) + 32'(frame));
    endfunction

    logic sck_rise;

    sck_rise_det u_sck_rise_det (
        .clk   (FPGA_CLK),
        .rst_n (FPGA_RST),
        .sck   (SENSOR_CLK),
        .rise  (sck_rise)
    );

    sensor_state_t      state, nxt_state;
    logic [INTEG_W-1:0] integ_cnt, nxt_integ_cnt;
    logic [LEAD_W-1:0]  lead_cnt, nxt_lead_cnt;
    logic [PIX_W-1:0]   pix, nxt_pix;
    logic               last_done, nxt_last_done;
    logic [DATA_W-1:0]  nxt_video;
    logic               nxt_pix_valid, nxt_eos, nxt_eoc;
    logic [INTEG_W-1:0] nxt_integ_len;
    logic [FRAME_W-1:0] nxt_frame_cnt;
    logic               emit;
    logic [PIX_W-1:0]   emit_idx;
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
    logic               nxt_st_err;
`endif

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
        if (!FPGA_RST) begin
            state     <= IDLE;
            integ_cnt <= '0;
            lead_cnt  <= '0;
            pix       <= '0;
            last_done <= 1'b0;
            VIDEO     <= '0;
            PIX_VALID <= 1'b0;
            EOS       <= 1'b0;
            EOC       <= 1'b0;
            INTEG_LEN <= '0;
            FRAME_CNT <= '0;
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
            ST_ERR    <= 1'b0;
`endif
        end else begin
            state     <= nxt_state;
            integ_cnt <= nxt_integ_cnt;
            lead_cnt  <= nxt_lead_cnt;
            pix       <= nxt_pix;
            last_done <= nxt_last_done;
            VIDEO     <= nxt_video;
            PIX_VALID <= nxt_pix_valid;
            EOS       <= nxt_eos;
            EOC       <= nxt_eoc;
            INTEG_LEN <= nxt_integ_len;
            FRAME_CNT <= nxt_frame_cnt;
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
            ST_ERR    <= nxt_st_err;
`endif
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_integ_cnt = integ_cnt;
        nxt_lead_cnt  = lead_cnt;
        nxt_pix       = pix;
        nxt_last_done = last_done;
        nxt_video     = VIDEO;
        nxt_pix_valid = 1'b0;
        nxt_eos       = 1'b0;
        nxt_eoc       = EOC;
        nxt_integ_len = INTEG_LEN;
        nxt_frame_cnt = FRAME_CNT;
        emit          = 1'b0;
        emit_idx      = '0;
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
        nxt_st_err    = ST_ERR;
`endif

        if (sck_rise) begin
            case (state)
                IDLE: begin
                    if (ST) begin
                        nxt_state     = INTEG;
                        nxt_integ_cnt = INTEG_W'(1);
                    end
                end
                INTEG: begin
                    if (ST) begin
                        if (integ_cnt != '1) begin
                            nxt_integ_cnt = integ_cnt + INTEG_W'(1);
                        end
                    end else begin
                        nxt_integ_len = integ_cnt;
                        nxt_lead_cnt  = LEAD_W'(1);
                        nxt_state     = LEAD_WAIT;
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
                        if (integ_cnt < INTEG_W'(MIN_INTEG)) begin
                            nxt_st_err = 1'b1;
                        end
`endif
                    end
                end
                LEAD_WAIT: begin
                    // Pixel 0 goes out on the same rise that ends the lead-in.
                    if (lead_cnt == LEAD_W'(LEAD)) begin
                        nxt_state = READOUT;
                        emit      = 1'b1;
                        emit_idx  = '0;
                    end else begin
                        nxt_lead_cnt = lead_cnt + LEAD_W'(1);
                    end
                end
                READOUT: begin
                    // After the last pixel, one further rise raises EOC.
                    if (last_done) begin
                        nxt_state     = EOC_HI;
                        nxt_eoc       = 1'b1;
                        nxt_last_done = 1'b0;
                    end else begin
                        emit     = 1'b1;
                        emit_idx = pix;
                    end
                end
                EOC_HI: begin
                    nxt_eoc       = 1'b0;
                    nxt_frame_cnt = FRAME_CNT + FRAME_W'(1);
                    nxt_state     = IDLE;
                end
                default: nxt_state = IDLE;
            endcase

`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
            if (ST && (state == LEAD_WAIT || state == READOUT || state == EOC_HI)) begin
                nxt_st_err = 1'b1;
            end
`endif
        end

        if (emit) begin
            nxt_video     = pixel_value(emit_idx, FRAME_CNT);
            nxt_pix_valid = 1'b1;
            if (emit_idx == PIX_W'(N_PIX - 1)) begin
                nxt_eos       = 1'b1;
                nxt_last_done = 1'b1;
            end else begin
                nxt_pix = emit_idx + PIX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_linear_sensor_model.sv
// tb_linear_sensor_model
//   Self-checking bench for linear_sensor_model with N_PIX = 8, LEAD = 2,
//   SENSOR_CLK = FPGA_CLK / 16. Expected pixels are queued as stimulus is
//   driven and compared by a monitor as PIX_VALID strobes appear.
//   Optional ST_ERR tests run when LINEAR_SENSOR_MODEL_CHECK_EN is defined.
module tb_linear_sensor_model;

    localparam int N_PIX   = 8;
    localparam int LEAD    = 2;
    localparam int DATA_W  = 12;
    localparam int INTEG_W = 21;
    localparam int FRAME_W = 16;

    logic               FPGA_CLK;
    logic               FPGA_RST;
    logic               SENSOR_CLK;
    logic               ST;
    logic [DATA_W-1:0]  VIDEO;
    logic               PIX_VALID;
    logic               EOS;
    logic               EOC;
    logic [INTEG_W-1:0] INTEG_LEN;
    logic [FRAME_W-1:0] FRAME_CNT;
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
    logic               ST_ERR;
`endif

    linear_sensor_model #(
        .N_PIX   (N_PIX),
        .LEAD    (LEAD),
        .DATA_W  (DATA_W),
        .INTEG_W (INTEG_W),
        .FRAME_W (FRAME_W)
    ) dut (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST   (FPGA_RST),
        .SENSOR_CLK (SENSOR_CLK),
        .ST         (ST),
        .VIDEO      (VIDEO),
        .PIX_VALID  (PIX_VALID),
        .EOS        (EOS),
        .EOC        (EOC),
        .INTEG_LEN  (INTEG_LEN),
        .FRAME_CNT  (FRAME_CNT)
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
        ,
        .ST_ERR     (ST_ERR)
`endif
    );

    initial FPGA_CLK = 1'b0;
    always #5 FPGA_CLK = ~FPGA_CLK;

    typedef struct {
        logic [DATA_W-1:0] video;
        logic              eos;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pix_seen = 0;
    int   eoc_count = 0;
    int   eoc_len = 0;
    int   last_eoc_len = 0;

    // Scoreboard monitor: compares every strobe against the queued model.
    always @(negedge FPGA_CLK) begin
        if (FPGA_RST) begin
            if (PIX_VALID) begin
                pix_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel video=%0d eos=%0b required none", VIDEO, EOS);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if ({VIDEO, EOS} !== {e.video, e.eos}) begin
                        errors++;
                        $display("FAIL pixel video=%0d eos=%0b required video=%0d eos=%0b",
                                 VIDEO, EOS, e.video, e.eos);
                    end
                end
            end else if (EOS) begin
                checks++;
                errors++;
                $display("FAIL eos_without_valid eos=1 required 0");
            end
            if (EOC) begin
                eoc_len++;
            end else if (eoc_len != 0) begin
                last_eoc_len = eoc_len;
                eoc_count++;
                eoc_len = 0;
            end
        end else begin
            eoc_len = 0;
        end
    end

    task automatic drive_rises(input int n, input logic st_val);
        for (int i = 0; i < n; i++) begin
            ST = st_val;
            SENSOR_CLK = 1'b0;
            repeat (8) @(negedge FPGA_CLK);
            SENSOR_CLK = 1'b1;
            repeat (8) @(negedge FPGA_CLK);
        end
    endtask

    task automatic push_frame(input int offset);
        for (int i = 0; i < N_PIX; i++) begin
            exp_q.push_back('{video: DATA_W'(i + offset), eos: (i == N_PIX - 1)});
        end
    endtask

    task automatic pulse_reset();
        @(negedge FPGA_CLK);
        #2 FPGA_RST = 1'b0;
        repeat (2) @(negedge FPGA_CLK);
        FPGA_RST = 1'b1;
    endtask

    task automatic test_reset();
        FPGA_RST = 1'b1;
        SENSOR_CLK = 1'b0;
        ST = 1'b0;
        #2 FPGA_RST = 1'b0;
        repeat (3) @(negedge FPGA_CLK);
        checks++;
        if ({VIDEO, PIX_VALID, EOS, EOC, INTEG_LEN, FRAME_CNT} !== '0) begin
            errors++;
            $display("FAIL reset_outputs video=%0d pv=%0b eos=%0b eoc=%0b integ=%0d frame=%0d required all 0",
                     VIDEO, PIX_VALID, EOS, EOC, INTEG_LEN, FRAME_CNT);
        end
        FPGA_RST = 1'b1;
        repeat (2) @(negedge FPGA_CLK);
    endtask

    task automatic test_first_frame();
        int base;
        base = pix_seen;
        push_frame(0);
        drive_rises(10, 1'b1);
        drive_rises(1, 1'b0);
        checks++;
        if (INTEG_LEN !== INTEG_W'(10)) begin
            errors++;
            $display("FAIL integ_len got %0d required 10", INTEG_LEN);
        end
        drive_rises(1, 1'b0);
        checks++;
        if (pix_seen !== base) begin
            errors++;
            $display("FAIL lead_no_pixel got %0d pixels required %0d", pix_seen - base, 0);
        end
        drive_rises(1, 1'b0);
        checks++;
        if (pix_seen !== base + 1) begin
            errors++;
            $display("FAIL first_pixel_latency got %0d pixels required 1", pix_seen - base);
        end
        drive_rises(7, 1'b0);
        checks++;
        if (pix_seen !== base + N_PIX) begin
            errors++;
            $display("FAIL pixel_count got %0d required %0d", pix_seen - base, N_PIX);
        end
        drive_rises(1, 1'b0);
        checks++;
        if (EOC !== 1'b1) begin
            errors++;
            $display("FAIL eoc_high got %0b required 1", EOC);
        end
        drive_rises(1, 1'b0);
        checks++;
        if ({EOC, FRAME_CNT} !== {1'b0, FRAME_W'(1)}) begin
            errors++;
            $display("FAIL frame_end eoc=%0b frame=%0d required eoc=0 frame=1", EOC, FRAME_CNT);
        end
        drive_rises(1, 1'b0);
        checks++;
        if (eoc_count !== 1 || last_eoc_len !== 16) begin
            errors++;
            $display("FAIL eoc_width count=%0d len=%0d required count=1 len=16", eoc_count, last_eoc_len);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL frame1_drain left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_second_frame();
        push_frame(1);
        drive_rises(10, 1'b1);
        drive_rises(13, 1'b0);
        checks++;
        if (FRAME_CNT !== FRAME_W'(2) || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL frame2 frame=%0d left=%0d required frame=2 left=0", FRAME_CNT, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_readout();
        int seen0, eoc0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{video: DATA_W'(i + 2), eos: 1'b0});
        end
        drive_rises(10, 1'b1);
        drive_rises(6, 1'b0);
        seen0 = pix_seen;
        eoc0 = eoc_count;
        @(negedge FPGA_CLK);
        #2 FPGA_RST = 1'b0;
        #1;
        checks++;
        if ({VIDEO, PIX_VALID, EOS, EOC, INTEG_LEN, FRAME_CNT} !== '0) begin
            errors++;
            $display("FAIL async_reset video=%0d pv=%0b eos=%0b eoc=%0b integ=%0d frame=%0d required all 0",
                     VIDEO, PIX_VALID, EOS, EOC, INTEG_LEN, FRAME_CNT);
        end
        repeat (2) @(negedge FPGA_CLK);
        FPGA_RST = 1'b1;
        drive_rises(14, 1'b0);
        checks++;
        if (pix_seen !== seen0 || eoc_count !== eoc0 || FRAME_CNT !== '0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL after_reset_idle pixels=%0d eocs=%0d frame=%0d left=%0d required 0 0 0 0",
                     pix_seen - seen0, eoc_count - eoc0, FRAME_CNT, exp_q.size());
        end
        push_frame(0);
        drive_rises(3, 1'b1);
        drive_rises(12, 1'b0);
        checks++;
        if (INTEG_LEN !== INTEG_W'(3) || FRAME_CNT !== FRAME_W'(1) || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL restart integ=%0d frame=%0d left=%0d required 3 1 0",
                     INTEG_LEN, FRAME_CNT, exp_q.size());
        end
    endtask

    task automatic test_sck_high_reset();
        @(negedge FPGA_CLK);
        SENSOR_CLK = 1'b1;
        ST = 1'b1;
        #2 FPGA_RST = 1'b0;
        repeat (3) @(negedge FPGA_CLK);
        FPGA_RST = 1'b1;
        repeat (20) @(negedge FPGA_CLK);
        push_frame(0);
        // A false rise at release would make this integration one longer.
        drive_rises(4, 1'b1);
        drive_rises(1, 1'b0);
        checks++;
        if (INTEG_LEN !== INTEG_W'(4)) begin
            errors++;
            $display("FAIL sck_high_release integ=%0d required 4", INTEG_LEN);
        end
        drive_rises(11, 1'b0);
        checks++;
        if (FRAME_CNT !== FRAME_W'(1) || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sck_high_frame frame=%0d left=%0d required 1 0", FRAME_CNT, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int eoc0;
        eoc0 = eoc_count;
        for (int f = 0; f < 3; f++) begin
            push_frame(1 + f);
            drive_rises(7, 1'b1);
            drive_rises(1, 1'b0);
            checks++;
            if (INTEG_LEN !== INTEG_W'(7)) begin
                errors++;
                $display("FAIL b2b_integ frame%0d integ=%0d required 7", f, INTEG_LEN);
            end
            drive_rises(11, 1'b1);
            checks++;
            if (FRAME_CNT !== FRAME_W'(2 + f)) begin
                errors++;
                $display("FAIL b2b_frame_cnt got %0d required %0d", FRAME_CNT, 2 + f);
            end
        end
        drive_rises(2, 1'b0);
        checks++;
        if (exp_q.size() !== 0 || eoc_count !== eoc0 + 3 || FRAME_CNT !== FRAME_W'(4)) begin
            errors++;
            $display("FAIL b2b_end left=%0d eocs=%0d frame=%0d required 0 3 4",
                     exp_q.size(), eoc_count - eoc0, FRAME_CNT);
        end
    endtask

`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
    task automatic test_st_err();
        pulse_reset();
        checks++;
        if (ST_ERR !== 1'b0) begin
            errors++;
            $display("FAIL st_err_reset got %0b required 0", ST_ERR);
        end
        push_frame(0);
        drive_rises(10, 1'b1);
        drive_rises(4, 1'b0);
        drive_rises(1, 1'b1);
        checks++;
        if (ST_ERR !== 1'b1) begin
            errors++;
            $display("FAIL st_err_readout got %0b required 1", ST_ERR);
        end
        drive_rises(7, 1'b0);
        checks++;
        if (ST_ERR !== 1'b1 || FRAME_CNT !== FRAME_W'(1) || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL st_err_sticky err=%0b frame=%0d left=%0d required 1 1 0",
                     ST_ERR, FRAME_CNT, exp_q.size());
        end
        pulse_reset();
        push_frame(0);
        drive_rises(3, 1'b1);
        drive_rises(12, 1'b0);
        checks++;
        if (ST_ERR !== 1'b1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL st_err_short_integ err=%0b left=%0d required 1 0", ST_ERR, exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_reset_mid_readout();
        pulse_reset();
        test_sck_high_reset();
        test_back_to_back();
`ifdef LINEAR_SENSOR_MODEL_CHECK_EN
        test_st_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/linear_sensor_model.md
Name: linear_sensor_model

Overview:
- Behavioural/synthesisable model of the line-sensor side of the SENSOR_CLK/ST/EOC drive interface.
- Consumes the drive outputs (SENSOR_CLK, ST) and produces the sensor responses: pixel video stream, TRIG-style pixel strobes, EOS, and EOC.
- Runs in the FPGA_CLK domain; SENSOR_CLK is treated as a data input and edge-detected.
- Used in loopback benches and on-board self-test, in place of the real sensor, to exercise the drive chain and the EOC detect/count path.

Parameters:
- N_PIX, 1024, pixels per line.
- LEAD, 48, SENSOR_CLK rising edges from ST falling to first pixel.
- DATA_W, 12, video sample width.
- INTEG_W, 21, integration counter width.
- FRAME_W, 16, frame counter width.

Ports:
- FPGA_CLK  input  1  system clock; all logic on posedge.
- FPGA_RST  input  1  asynchronous, active-low reset.
- SENSOR_CLK  input  1  divided sensor clock; sampled as data.
- ST  input  1  start/integration request; sampled on SENSOR_CLK rise.
- VIDEO  output  DATA_W  current pixel value; held between strobes.
- PIX_VALID  output  1  one-FPGA_CLK pulse per pixel.
- EOS  output  1  one-FPGA_CLK pulse, coincident with the last PIX_VALID.
- EOC  output  1  level; high for exactly one SENSOR_CLK period after readout.
- INTEG_LEN  output  INTEG_W  integration length of the last frame, in SENSOR_CLK rises.
- FRAME_CNT  output  FRAME_W  completed frames, wraps at 2^FRAME_W.

Behaviour:
- Edge detect:
  - sck_q <= SENSOR_CLK every cycle; sck_q resets to 1, so SENSOR_CLK already high at reset release does not cause a false rise.
  - sck_rise = SENSOR_CLK & ~sck_q (combinational).
  - All state changes occur on the FPGA_CLK edge where sck_rise = 1, so response latency is 1 FPGA_CLK after the rise is sampled.
- Reset values: state IDLE; all counters 0; VIDEO 0, PIX_VALID 0, EOS 0, EOC 0, INTEG_LEN 0, FRAME_CNT 0.
- Reset may assert at any time: all activity aborts immediately, and no partial EOS/EOC is produced.
- States: IDLE, INTEG, LEAD_WAIT, READOUT, EOC_HI.
- IDLE:
  - On a rise with ST = 1: go to INTEG, integ_cnt = 1.
  - ST = 0: stay in IDLE.
- INTEG:
  - On a rise with ST = 1: integ_cnt++, saturating at all-ones.
  - On a rise with ST = 0: INTEG_LEN <= integ_cnt, lead_cnt = 1, go to LEAD_WAIT.
- LEAD_WAIT:
  - On each rise, lead_cnt++.
  - On the rise where lead_cnt == LEAD: go to READOUT with pix = 0, and emit pixel 0 on that same rise.
  - LEAD = 1 therefore emits pixel 0 on the first rise after ST is sampled low.
- READOUT:
  - Each rise emits pixel pix: VIDEO <= (pix + FRAME_CNT) mod 2^DATA_W, PIX_VALID pulses 1 cycle, then pix++.
  - When pix == N_PIX-1, EOS pulses together with PIX_VALID; the next rise enters EOC_HI.
- EOC_HI:
  - EOC = 1 from the entering rise until the next rise.
  - On that next rise: EOC <= 0, FRAME_CNT++, go to IDLE.
- ST is ignored in LEAD_WAIT, READOUT and EOC_HI.
- A new frame needs ST sampled high on a rise while in IDLE; ST held high continuously starts the next frame 1 rise after returning to IDLE.
- SENSOR_CLK stopped: state holds indefinitely.
- Pixel index width: $clog2(N_PIX).

Optional Feature:
- Macro: LINEAR_SENSOR_MODEL_CHECK_EN.
- Defined: adds output ST_ERR (1 bit, reset 0, sticky until reset).
  - ST_ERR sets if ST is sampled high on a rise in LEAD_WAIT, READOUT or EOC_HI.
  - ST_ERR also sets if integration ends with integ_cnt < 6.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package linear_sensor_model_pkg holds:
  - state enum sensor_state_t;
  - default constants: N_PIX_DEF = 1024, LEAD_DEF = 48, MIN_INTEG = 6.
- One sub-module: sck_rise_det (sck_q register with reset-to-1, plus the sck_rise output).

Test Plan (N_PIX = 8, LEAD = 2, DATA_W = 12, SENSOR_CLK = FPGA_CLK / 16):
- ST high for 10 rises, then low -> INTEG_LEN = 10; 2 rises later the first PIX_VALID, VIDEO = 0; 8 strobes with VIDEO 0..7; EOS on the 8th; EOC high one SENSOR_CLK period; FRAME_CNT = 1.
- Second frame -> VIDEO 1..8 (offset by FRAME_CNT = 1); FRAME_CNT = 2.
- Reset asserted mid-READOUT (after pixel 3) -> all outputs 0 asynchronously; no EOS/EOC; after release, IDLE until ST is sampled high.
- SENSOR_CLK held high through reset release -> no state change until a genuine low-to-high transition.
- ST held high continuously -> back-to-back frames with exactly 1 IDLE rise between EOC falling and INTEG entry; INTEG_LEN identical each frame.
- CHECK_EN: ST pulsed high during READOUT -> ST_ERR = 1 and remains set, readout unaffected; a separate run with integration of 3 rises -> ST_ERR = 1.
